// File: rtl/dlx_pkg.sv
// DLX shift-instruction encodings, shift-ALU op codes, issue FSM states and
// the decoder shared by the shift issue sequencer.
package dlx_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_SLLI  = 6'h14;
   localparam logic [5:0] OPC_SRLI  = 6'h16;
   localparam logic [5:0] OPC_SRAI  = 6'h17;

   localparam logic [5:0] FN_SLL = 6'h04;
   localparam logic [5:0] FN_SRL = 6'h06;
   localparam logic [5:0] FN_SRA = 6'h07;

   localparam logic [2:0] SOP_SLL = 3'b000;
   localparam logic [2:0] SOP_SLA = 3'b001;
   localparam logic [2:0] SOP_SRL = 3'b010;
   localparam logic [2:0] SOP_SRA = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD1  = 3'd1,
      S_RD2  = 3'd2,
      S_CAP  = 3'd3,
      S_EXEC = 3'd4,
      S_WB   = 3'd5
   } state_e;

   typedef struct packed {
      logic       legal;
      logic       rtype;
      logic [2:0] op;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d = '{legal: 1'b0, rtype: 1'b0, op: SOP_SLL};
      case (w[31:26])
         OPC_RTYPE: begin
            d.rtype = 1'b1;
            case (w[5:0])
               FN_SLL:  begin d.legal = 1'b1; d.op = SOP_SLL; end
               FN_SRL:  begin d.legal = 1'b1; d.op = SOP_SRL; end
               FN_SRA:  begin d.legal = 1'b1; d.op = SOP_SRA; end
               default: d.legal = 1'b0;
            endcase
         end
         OPC_SLLI: begin d.legal = 1'b1; d.op = SOP_SLL; end
         OPC_SRLI: begin d.legal = 1'b1; d.op = SOP_SRL; end
         OPC_SRAI: begin d.legal = 1'b1; d.op = SOP_SRA; end
         default:  d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/shift_issue.sv
// Shift-instruction issue sequencer: decodes DLX shifts, fetches operands from
// the register file, strobes an external shift ALU and writes the result back.
module shift_issue
   import dlx_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   output logic [4:0]  rf_raddr,
   input  logic [31:0] rf_rdata,
   output logic        alu_enable,
   output logic [31:0] alu_in,
   output logic [4:0]  alu_shift,
   output logic [2:0]  alu_op,
   input  logic [32:0] alu_result,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        shift_flag,
   output logic        busy,
   output logic        illegal
);

   state_e      state_q, state_d;
   dec_t        dec;
   logic        accept;
   logic        rtype_q, bypass_q;
   logic [2:0]  op_q;
   logic [4:0]  rd_q, rs2_q, imm_q;
   logic [31:0] op1_q;
   logic [4:0]  rf_raddr_q;
   logic        alu_enable_q, illegal_q, shift_flag_q;
   logic [31:0] alu_in_q;
   logic [4:0]  alu_shift_q;
   logic [2:0]  alu_op_q;
   logic [31:0] cap_op1, wb_data;
   logic [4:0]  cap_sh;
   logic        in_wb, wb_flag;

   always_comb begin
      dec     = decode(instr);
      accept  = instr_valid && (state_q == S_IDLE);
      // R-type operand arrived in RD2; I-type operand is on rf_rdata now
      cap_op1 = rtype_q ? op1_q : rf_rdata;
      cap_sh  = rtype_q ? rf_rdata[4:0] : imm_q;
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept && dec.legal) state_d = S_RD1;
         S_RD1:   state_d = rtype_q ? S_RD2 : S_CAP;
         S_RD2:   state_d = S_CAP;
         S_CAP:   state_d = (cap_sh == 5'd0) ? S_WB : S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         rtype_q      <= 1'b0;
         bypass_q     <= 1'b0;
         op_q         <= SOP_SLL;
         rd_q         <= '0;
         rs2_q        <= '0;
         imm_q        <= '0;
         op1_q        <= '0;
         rf_raddr_q   <= '0;
         alu_enable_q <= 1'b0;
         alu_in_q     <= '0;
         alu_shift_q  <= '0;
         alu_op_q     <= SOP_SLL;
         illegal_q    <= 1'b0;
         shift_flag_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         illegal_q    <= accept && !dec.legal;
         alu_enable_q <= 1'b0;
         if (accept && dec.legal) begin
            rtype_q    <= dec.rtype;
            op_q       <= dec.op;
            rd_q       <= dec.rtype ? instr[15:11] : instr[20:16];
            rs2_q      <= instr[20:16];
            imm_q      <= instr[4:0];
            rf_raddr_q <= instr[25:21];
         end
         if (state_q == S_RD1 && rtype_q) rf_raddr_q <= rs2_q;
         if (state_q == S_RD2) op1_q <= rf_rdata;
         if (state_q == S_CAP) begin
            op1_q    <= cap_op1;
            bypass_q <= (cap_sh == 5'd0);
            if (cap_sh != 5'd0) begin
               alu_enable_q <= 1'b1;
               alu_in_q     <= cap_op1;
               alu_shift_q  <= cap_sh;
               alu_op_q     <= op_q;
            end
         end
         if (in_wb) shift_flag_q <= wb_flag;
      end
   end

   // Write-back is combinational off WB because alu_result only lands in that cycle
   always_comb begin
      in_wb   = (state_q == S_WB);
      wb_data = bypass_q ? op1_q : alu_result[31:0];
      wb_flag = !bypass_q && alu_result[32];
   end

   assign instr_ready = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign illegal     = illegal_q;
   assign rf_raddr    = rf_raddr_q;
   assign alu_enable  = alu_enable_q;
   assign alu_in      = alu_in_q;
   assign alu_shift   = alu_shift_q;
   assign alu_op      = alu_op_q;
   assign rf_we       = in_wb && (rd_q != 5'd0);
   assign rf_waddr    = in_wb ? rd_q : 5'd0;
   assign rf_wdata    = in_wb ? wb_data : 32'd0;
   assign shift_flag  = in_wb ? wb_flag : shift_flag_q;

endmodule
